// File: rtl/enum_record_serializer_if.sv
// Record-in / beat-out stream bundle for enum_record_serializer.
// slave is the serializer's view; master is the producer/consumer environment.
interface enum_record_serializer_if #(
    parameter int FOO_W  = 32,
    parameter int BAR_W  = 32,
    parameter int KIND_W = 3,
    parameter int OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [FOO_W-1:0]  in_foo;
    logic [BAR_W-1:0]  in_bar;
    logic [KIND_W-1:0] in_kind;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_foo, in_bar, in_kind, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_foo, in_bar, in_kind, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/enum_record_serializer.sv
// Accepts {foo, bar, kind} records, drops and counts illegal kinds, and
// streams legal ones out as OUT_W-bit beats, LSB first.
//
// state   | meaning
// ST_IDLE | ready for a record; illegal kinds are counted here and dropped
// ST_SEND | presenting beat r_idx of the latched record
module enum_record_serializer #(
    parameter int FOO_W    = 32,
    parameter int BAR_W    = 32,
    parameter int KIND_W   = 3,
    parameter int KIND_MAX = 4,
    parameter int OUT_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    enum_record_serializer_if.slave bus,
    output logic [ERR_W-1:0]        err_count,
    output logic                    busy
);
    localparam int REC_W  = KIND_W + BAR_W + FOO_W;
    localparam int NBEATS = (REC_W + OUT_W - 1) / OUT_W;
    localparam int PAD_W  = NBEATS * OUT_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_M1 = IDX_W'((NBEATS > 1) ? NBEATS - 2 : 0);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t            r_state;
    logic [PAD_W-1:0]  r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_in_ready;
    logic              r_busy;
    logic [ERR_W-1:0]  r_err;

    logic [PAD_W-1:0]  w_packed;
    logic              w_kind_ok;

    // Zero-extension fills the unused top bits of the final beat.
    assign w_packed  = PAD_W'({bus.in_kind, bus.in_bar, bus.in_foo});
    assign w_kind_ok = (32'(bus.in_kind) <= KIND_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_kind_ok) begin
                            r_shift     <= w_packed;
                            r_idx       <= '0;
                            r_out_last  <= (NBEATS == 1);
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_SEND;
                        end else if (r_err != '1) begin
                            r_err <= r_err + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // The current beat always sits in the low OUT_W bits of r_shift.
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_shift     <= '0;
                            r_idx       <= '0;
                            r_out_last  <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_shift    <= r_shift >> OUT_W;
                            r_idx      <= r_idx + 1'b1;
                            r_out_last <= (r_idx == LAST_M1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_shift[OUT_W-1:0];
    assign bus.out_last  = r_out_last;
    assign err_count     = r_err;
    assign busy          = r_busy;
endmodule
